// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the extended synchronous FIFO.
package fifo_pkg;
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, threshold and sticky error bookkeeping for the FIFO.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int PW       = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic          wr_ok,
    output logic          rd_ok,
    output logic [PW-2:0] wr_addr,
    output logic [PW-2:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [PW-1:0] count,
    output logic          overflow,
    output logic          underflow
);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [PW-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s, cnt_nxt_s;
    logic          full_s, empty_s, wr_ok_s, rd_ok_s;
    logic          af_r, ae_r, ovf_r, unf_r;

    // Accept decisions and next-state pointers from the pre-edge pointers.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        rd_ok_s = rd_en & ~empty_s;
        // A full FIFO still takes a write when the same edge frees a slot.
        wr_ok_s = wr_en & (~full_s | rd_ok_s);
        if (wr_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        cnt_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Pointer advance, registered threshold flags and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            af_r     <= (cnt_nxt_s >= PW'(AF_LEVEL));
            ae_r     <= (cnt_nxt_s <= PW'(AE_LEVEL));
            ovf_r    <= (wr_en & ~wr_ok_s) | (ovf_r & ~clr_err);
            unf_r    <= (rd_en & ~rd_ok_s) | (unf_r & ~clr_err);
        end
    end

    assign wr_ok        = wr_ok_s;
    assign rd_ok        = rd_ok_s;
    assign wr_addr      = wr_ptr_r[AW-1:0];
    assign rd_addr      = rd_ptr_r[AW-1:0];
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign count        = wr_ptr_r - rd_ptr_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;
endmodule

// File: rtl/synchronous_fifo_ext.sv
// Synchronous FIFO with thresholds, occupancy, sticky errors and a
// selectable registered or first-word-fall-through read port.
module synchronous_fifo_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = FWFT_OFF,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  wr_ok_s, rd_ok_s;
    logic [ADDR_W-1:0]     wr_addr_s, rd_addr_s;

    fifo_ptr_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL),
        .PW       (ADDR_W + 1)
    ) u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .wr_ok        (wr_ok_s),
        .rd_ok        (rd_ok_s),
        .wr_addr      (wr_addr_s),
        .rd_addr      (rd_addr_s),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage write; contents survive reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_s) begin
            mem_r[wr_addr_s] <= din;
        end
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        assign dout       = mem_r[rd_addr_s];
        assign dout_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_r;
        logic                  dout_valid_r;

        // Registered read: data lands one cycle after an accepted read.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_r       <= '0;
                dout_valid_r <= 1'b0;
            end else begin
                dout_valid_r <= rd_ok_s;
                if (rd_ok_s) begin
                    dout_r <= mem_r[rd_addr_s];
                end
            end
        end

        assign dout       = dout_r;
        assign dout_valid = dout_valid_r;
    end
endmodule

// File: doc/synchronous_fifo_ext.md
Name: synchronous_fifo_ext

Overview:
- Parametrised successor to the basic synchronous FIFO: single clock, synchronous active-high reset.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count and a selectable read mode: standard registered read, or first-word-fall-through (FWFT).
- Adds sticky overflow/underflow error flags with a clear input.
- Used as the general-purpose buffer between streaming producers and consumers in the datapath.

Parameters:
- DATA_WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2.
- AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- ADDR_W, $clog2(DEPTH), derived; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  write request.
- din  input  DATA_WIDTH  write data.
- rd_en  input  1  read request (FWFT: acknowledge/pop of the word on dout).
- dout  output  DATA_WIDTH  read data.
- dout_valid  output  1  dout holds a valid word (meaning per mode, see Behaviour).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_LEVEL.
- almost_empty  output  1  count ≤ AE_LEVEL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- clr_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
- Pointers: wr_ptr and rd_ptr, each ADDR_W+1 bits with a wrap bit. full/empty are derived from pointer compare. count = wr_ptr - rd_ptr modulo 2^(ADDR_W+1).
- Reset, when rst=1 at an edge:
  - Pointers reset to 0; count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - dout=0, dout_valid=0, overflow=0, underflow=0.
  - Array contents are not cleared.
  - rst has priority over every other input. A reset mid-transfer discards all contents.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = rd_en & !empty.
  - wr_ok = wr_en & (!full | rd_ok). A write into a full FIFO succeeds when a read is accepted on the same edge.
  - Empty with both requests: the write is accepted, the read is rejected, underflow is set. FWFT behaves the same; the new word appears next cycle.
  - wr_en & !wr_ok sets overflow. rd_en & !rd_ok sets underflow.
  - Rejected operations do not modify pointers, data or count.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Status timing: all flags are registered, or derived from registered pointers, and reflect post-edge state in the cycle after the edge. No flag is combinational on wr_en/rd_en.
- Pointer wrap: the index wraps from DEPTH-1 to 0 and the wrap bit toggles. Wrapping is continuous; no special handling is needed.
- FWFT=0 (standard mode):
  - On rd_ok, dout <= mem[rd_ptr] at that edge, so data is available 1 cycle after the request.
  - dout_valid=1 for exactly the cycle after each rd_ok, otherwise 0.
  - dout holds its last value when no read is accepted.
- FWFT=1 (first-word-fall-through):
  - dout = mem[rd_ptr], a combinational read of the array; dout_valid = !empty.
  - A word written at edge N is visible on dout in cycle N+1.
  - rd_en pops the presented word. dout is don't-care when dout_valid=0.
- Error flags:
  - clr_err clears overflow/underflow at the edge.
  - If a new error and clr_err occur on the same edge, the flag is set (set wins).

Decomposition:
- Shared package fifo_pkg:
  - Helper function for the pointer width.
  - Localparam constants FWFT_OFF=0 and FWFT_ON=1, used for the mode parameter.
- One natural sub-module, fifo_ptr_ctrl:
  - Contains the pointers, count, full/empty/almost flags and error flags.
  - Parameters: DEPTH, AF_LEVEL, AE_LEVEL.
- Top level: storage array and read-mode output logic.

Test Plan:
- Reset/flags: FWFT=0, defaults. Hold rst=1 for 2 cycles -> empty=1, almost_empty=1, count=0, dout=0, dout_valid=0, overflow=underflow=0.
- Fill/drain with thresholds:
  - Write 1..16 -> almost_full rises in the cycle after the 12th write; full=1 and count=16 after the 16th.
  - Read 16 -> dout=1..16 in order, each 1 cycle after its rd_en with a dout_valid pulse.
  - almost_empty rises when count returns to 4; empty=1 at the end.
- Errors:
  - Write 8'h55 when full with rd_en=0 -> overflow=1; count stays 16; contents unchanged.
  - Drain, then rd_en on empty -> underflow=1.
  - Pulse clr_err -> both clear next cycle.
  - clr_err together with a rejected write -> overflow stays 1.
- Simultaneous operations:
  - Full: wr_en=rd_en=1 with din=8'hAA -> count stays 16, no overflow; 8'hAA is read out last.
  - Empty: both high with din=8'hBB -> count=1, underflow=1.
- FWFT=1:
  - Write 8'hAA at edge N -> dout=8'hAA and dout_valid=1 in cycle N+1 without rd_en.
  - Write 8'hBB, then pulse rd_en -> dout=8'hBB; a second rd_en -> dout_valid=0, empty=1.
- Wrap/reset mid-op:
  - Run 40 cycles of alternating 3-write/2-read bursts with incrementing data -> scoreboard matches order across pointer wrap.
  - Assert rst with count=7 -> count=0, empty=1, next read rejected.
